// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program memory and hands words one at a
// time to a downstream controller using a start/valid handshake.
`ifndef I_WIDTH
`define I_WIDTH 32
`endif

module instr_sequencer #(
  parameter int I_WIDTH    = `I_WIDTH,
  parameter int PROG_DEPTH = 16,
  localparam int PA_W      = $clog2(PROG_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               prog_we_i,
  input  logic [PA_W-1:0]    prog_addr_i,
  input  logic [I_WIDTH-1:0] prog_data_i,
  input  logic [PA_W:0]      prog_len_i,
  input  logic               run_i,
  input  logic               abort_i,
  input  logic               ctrl_valid_i,
  output logic               start_o,
  output logic [I_WIDTH-1:0] instruction_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [PA_W-1:0]    pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RELEASE,
    S_FINISH
  } state_t;

  state_t               state_q;
  logic [PA_W-1:0]      pc_q;
  logic [PA_W:0]        len_q;
  logic                 start_q;
  logic [I_WIDTH-1:0]   instr_q;
  logic                 busy_q;
  logic                 done_q;
  logic [I_WIDTH-1:0]   mem_q [PROG_DEPTH];

  logic [PA_W:0]        len_d;
  logic [PA_W:0]        last_idx;
  logic                 pc_last;

  // Requested lengths beyond the memory size simply run the whole program.
  assign len_d    = (prog_len_i > (PA_W+1)'(PROG_DEPTH)) ? (PA_W+1)'(PROG_DEPTH) : prog_len_i;
  assign last_idx = len_q - (PA_W+1)'(1);
  assign pc_last  = ({1'b0, pc_q} == last_idx);

  // Program memory is deliberately outside the reset domain so reloads are not needed.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && !busy_q) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      start_q <= 1'b0;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (run_i) begin
            if (prog_len_i != '0) begin
              len_q   <= len_d;
              pc_q    <= '0;
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_FETCH: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            instr_q <= mem_q[pc_q];
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Abort outranks a simultaneous completion.
          if (abort_i) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (ctrl_valid_i) begin
            start_q <= 1'b0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!ctrl_valid_i) begin
            if (pc_last) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              pc_q    <= pc_q + PA_W'(1);
              state_q <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_o       = start_q;
  assign instruction_o = instr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected issues, a
// negedge monitor pops and compares each time start_o rises.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        prog_we_i = 1'b0;
  logic [3:0]  prog_addr_i = '0;
  logic [31:0] prog_data_i = '0;
  logic [4:0]  prog_len_i = '0;
  logic        run_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        ctrl_valid_i = 1'b0;
  logic        start_o;
  logic [31:0] instruction_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  pc_o;

  instr_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i),
    .prog_len_i   (prog_len_i),
    .run_i        (run_i),
    .abort_i      (abort_i),
    .ctrl_valid_i (ctrl_valid_i),
    .start_o      (start_o),
    .instruction_o(instruction_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pc_o         (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          issue_cnt = 0;
  int          done_cnt = 0;
  int          resp_lat = 13;
  logic        resp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] instr, input logic [3:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [31:0] data);
    prog_we_i   = 1'b1;
    prog_addr_i = addr;
    prog_data_i = data;
    step();
    prog_we_i   = 1'b0;
  endtask

  task automatic run_pulse(input logic [4:0] len);
    prog_len_i = len;
    run_i      = 1'b1;
    step();
    run_i      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    bit seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_issue(input string name, input int target, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (issue_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_issue_seen"}, 32'(seen), 32'd1);
  endtask

  // Downstream controller model: raises valid resp_lat cycles into an issue and
  // holds it until start_o drops.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #3;
      if (!start_o) begin
        ctrl_valid_i = 1'b0;
        cnt = 0;
      end else if (resp_en && !ctrl_valid_i) begin
        cnt++;
        if (cnt >= resp_lat) ctrl_valid_i = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        start_prev;
    logic        done_prev;
    logic        rel_pending;
    logic [31:0] cur_instr;
    exp_t        e;
    start_prev  = 1'b0;
    done_prev   = 1'b0;
    rel_pending = 1'b0;
    cur_instr   = '0;
    forever begin
      @(negedge clk);
      if (start_o && !start_prev) begin
        issue_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual instr=0x%08h pc=%0d required none", instruction_o, pc_o);
          cur_instr = instruction_o;
        end else begin
          e = exp_q.pop_front();
          chk("issue_instr", instruction_o, e.instr);
          chk("issue_pc", 32'(pc_o), 32'(e.pc));
          cur_instr = e.instr;
        end
      end else if (start_o && start_prev) begin
        chk("instr_stable", instruction_o, cur_instr);
      end
      if (rel_pending) chk("start_fall_after_valid", 32'(start_o), 32'd0);
      rel_pending = start_o && ctrl_valid_i && !abort_i && !rst_i;
      if (done_o) begin
        done_cnt++;
        chk("done_single_cycle", 32'(done_prev), 32'd0);
      end
      start_prev = start_o;
      done_prev  = done_o;
    end
  end

  initial begin
    int dbase;
    int ibase;
    bit hit;

    // Reset state
    repeat (3) step();
    rst_i = 1'b0;
    step();
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_instr", instruction_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pc", 32'(pc_o), 32'd0);

    // Three-word program, controller answers after 13 cycles
    resp_lat = 13;
    prog_write(4'd0, 32'h8000_0001);
    prog_write(4'd1, 32'h8000_0002);
    prog_write(4'd2, 32'h8000_0003);
    exp_push(32'h8000_0001, 4'd0);
    exp_push(32'h8000_0002, 4'd1);
    exp_push(32'h8000_0003, 4'd2);
    dbase = done_cnt;
    run_pulse(5'd3);
    wait_done("three", 400);
    step();
    chk("three_busy_after", 32'(busy_o), 32'd0);
    chk("three_start_after", 32'(start_o), 32'd0);
    repeat (5) step();
    chk("three_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("three_queue_empty", 32'(exp_q.size()), 32'd0);

    // Empty run
    dbase = done_cnt;
    ibase = issue_cnt;
    prog_len_i = 5'd0;
    run_i = 1'b1;
    step();
    run_i = 1'b0;
    chk("empty_done_pulse", 32'(done_o), 32'd1);
    chk("empty_busy", 32'(busy_o), 32'd0);
    chk("empty_start", 32'(start_o), 32'd0);
    step();
    chk("empty_done_low", 32'(done_o), 32'd0);
    chk("empty_busy_still", 32'(busy_o), 32'd0);
    repeat (3) step();
    chk("empty_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("empty_no_issue", 32'(issue_cnt - ibase), 32'd0);

    // Over-long length clamps to the full 16-entry program
    resp_lat = 2;
    for (int i = 0; i < 16; i++) begin
      prog_write(4'(i), 32'h1000_0000 + 32'(i));
      exp_push(32'h1000_0000 + 32'(i), 4'(i));
    end
    ibase = issue_cnt;
    run_pulse(5'd20);
    wait_done("clamp", 3000);
    step();
    chk("clamp_issue_count", 32'(issue_cnt - ibase), 32'd16);
    chk("clamp_pc_end", 32'(pc_o), 32'd15);
    chk("clamp_busy_after", 32'(busy_o), 32'd0);
    chk("clamp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Write while busy is ignored
    exp_push(32'h1000_0000, 4'd0);
    run_pulse(5'd1);
    prog_write(4'd0, 32'hDEAD_BEEF);
    wait_done("wbusy1", 200);
    step();
    exp_push(32'h1000_0000, 4'd0);
    run_pulse(5'd1);
    wait_done("wbusy2", 200);
    step();
    chk("wbusy_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort during the second issue, then restart from pc 0
    prog_write(4'd0, 32'h8000_0001);
    prog_write(4'd1, 32'h8000_0002);
    prog_write(4'd2, 32'h8000_0003);
    resp_lat = 20;
    exp_push(32'h8000_0001, 4'd0);
    exp_push(32'h8000_0002, 4'd1);
    ibase = issue_cnt;
    dbase = done_cnt;
    run_pulse(5'd3);
    wait_issue("abort", ibase + 2, 300);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_start", 32'(start_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    repeat (4) step();
    chk("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    resp_lat = 3;
    exp_push(32'h8000_0001, 4'd0);
    exp_push(32'h8000_0002, 4'd1);
    exp_push(32'h8000_0003, 4'd2);
    run_pulse(5'd3);
    wait_done("abort_rerun", 300);
    step();
    chk("abort_rerun_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in RELEASE
    resp_lat = 4;
    exp_push(32'h8000_0001, 4'd0);
    ibase = issue_cnt;
    dbase = done_cnt;
    run_pulse(5'd3);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (issue_cnt > ibase && !start_o && busy_o) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("rstmid_release_seen", 32'(hit), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rstmid_start", 32'(start_o), 32'd0);
    chk("rstmid_instr", instruction_o, 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_done", 32'(done_o), 32'd0);
    chk("rstmid_pc", 32'(pc_o), 32'd0);
    step();
    rst_i = 1'b0;
    repeat (4) step();
    chk("rstmid_no_done", 32'(done_cnt - dbase), 32'd0);
    chk("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_push(32'h8000_0001, 4'd0);
    exp_push(32'h8000_0002, 4'd1);
    exp_push(32'h8000_0003, 4'd2);
    run_pulse(5'd3);
    wait_done("rstmid_rerun", 300);
    step();
    chk("rstmid_rerun_queue", 32'(exp_q.size()), 32'd0);
    chk("rstmid_rerun_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
